// File: rtl/ts_ascii_serializer_if.sv
// ts_ascii_serializer_if: timestamp-in / ASCII-byte-out handshake bundle for the serializer.
interface ts_ascii_serializer_if #(
    parameter int TS_BITS   = 64,
    parameter int DATA_BITS = 8
);
    logic                 ts_valid;
    logic [TS_BITS-1:0]   ts_data;
    logic                 ts_ready;
    logic                 byte_valid;
    logic [DATA_BITS-1:0] byte_data;
    logic                 byte_ready;
    logic                 busy;
    modport master (output ts_valid, ts_data, byte_ready, input ts_ready, byte_valid, byte_data, busy);
    modport slave  (input ts_valid, ts_data, byte_ready, output ts_ready, byte_valid, byte_data, busy);
endinterface

// File: rtl/ts_ascii_serializer.sv
// ts_ascii_serializer: turns one timestamp word into a prefix + hex digits + CR LF byte stream.
module ts_ascii_serializer #(
    parameter int         TS_BITS     = 64,
    parameter int         DATA_BITS   = 8,
    parameter bit         EMIT_PREFIX = 1,
    parameter logic [7:0] PREFIX_CHAR = 8'h54,
    parameter bit         EMIT_CRLF   = 1,
    parameter bit         UPPERCASE   = 1
) (
    input logic                  clk,
    input logic                  rst,
    ts_ascii_serializer_if.slave bus
);
    localparam int NDIG = TS_BITS / 4;
    localparam int IW   = NDIG > 1 ? $clog2(NDIG) : 1;

    typedef enum logic [2:0] {IDLE, PREFIX, HEX, CR, LF} state_t;

    state_t               state_q, state_d;
    logic [TS_BITS-1:0]   sr_q, sr_d, sr_sh;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 bv_q, bv_d;
    logic [DATA_BITS-1:0] bd_q, bd_d;
    logic                 xfer;

    function automatic logic [7:0] enc(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'd0, n} : (UPPERCASE ? 8'h41 : 8'h61) + {4'd0, n} - 8'd10;
    endfunction

    assign xfer           = bv_q && bus.byte_ready;
    assign sr_sh          = sr_q << 4;
    assign bus.ts_ready   = !rst && state_q == IDLE;
    assign bus.byte_valid = bv_q;
    assign bus.byte_data  = bd_q;
    assign bus.busy       = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        idx_d   = idx_q;
        bv_d    = bv_q;
        bd_d    = bd_q;
        case (state_q)
            IDLE: if (bus.ts_valid) begin
                sr_d    = bus.ts_data;
                idx_d   = '0;
                bv_d    = 1'b1;
                state_d = EMIT_PREFIX ? PREFIX : HEX;
                bd_d    = EMIT_PREFIX ? PREFIX_CHAR : enc(bus.ts_data[TS_BITS-1 -: 4]);
            end
            PREFIX: if (xfer) begin
                state_d = HEX;
                bd_d    = enc(sr_q[TS_BITS-1 -: 4]);
            end
            HEX: if (xfer) begin
                sr_d  = sr_sh;
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(NDIG - 1)) begin
                    state_d = EMIT_CRLF ? CR : IDLE;
                    bv_d    = EMIT_CRLF;
                    bd_d    = EMIT_CRLF ? 8'h0D : bd_q;
                end else begin
                    bd_d = enc(sr_sh[TS_BITS-1 -: 4]);
                end
            end
            CR: if (xfer) begin
                state_d = LF;
                bd_d    = 8'h0A;
            end
            LF: if (xfer) begin
                state_d = IDLE;
                bv_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
            bv_q    <= 1'b0;
            bd_q    <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            idx_q   <= idx_d;
            bv_q    <= bv_d;
            bd_q    <= bd_d;
        end
    end
endmodule

// File: tb/tb_ts_ascii_serializer.sv
// tb_ts_ascii_serializer: directed checks of framing, backpressure, busy-ignore, reset abort and a narrow lowercase variant.
module tb_ts_ascii_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [7:0] exp1 [19] = '{8'h54, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                              8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h0D, 8'h0A};
    logic [7:0] exp3 [19] = '{8'h54, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46,
                              8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0D, 8'h0A};
    logic [7:0] exp4 [4]  = '{8'h62, 8'h65, 8'h65, 8'h66};

    ts_ascii_serializer_if #(.TS_BITS(64), .DATA_BITS(8)) i1 ();
    ts_ascii_serializer_if #(.TS_BITS(16), .DATA_BITS(8)) i4 ();

    ts_ascii_serializer u1 (.clk(clk), .rst(rst), .bus(i1.slave));
    ts_ascii_serializer #(.TS_BITS(16), .EMIT_PREFIX(0), .EMIT_CRLF(0), .UPPERCASE(0))
        u4 (.clk(clk), .rst(rst), .bus(i4.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [63:0] ts, input bit hold);
        i1.ts_data  = ts;
        i1.ts_valid = 1'b1;
        tick();
        i1.ts_valid = hold;
    endtask

    task automatic frame(input string tag, input logic [7:0] e [19], input int stall_at);
        for (int i = 0; i < 19; i++) begin
            chk({tag, "_valid"}, 64'(i1.byte_valid), 64'd1);
            chk({tag, "_data"}, 64'(i1.byte_data), 64'(e[i]));
            chk({tag, "_tsrdy_busy"}, 64'(i1.ts_ready), 64'd0);
            if (i == stall_at) begin
                i1.byte_ready = 1'b0;
                repeat (5) begin
                    tick();
                    chk({tag, "_stall_data"}, 64'(i1.byte_data), 64'(e[i]));
                    chk({tag, "_stall_valid"}, 64'(i1.byte_valid), 64'd1);
                end
                i1.byte_ready = 1'b1;
            end
            tick();
        end
        chk({tag, "_end_valid"}, 64'(i1.byte_valid), 64'd0);
        chk({tag, "_end_tsrdy"}, 64'(i1.ts_ready), 64'd1);
        chk({tag, "_end_busy"}, 64'(i1.busy), 64'd0);
    endtask

    initial begin
        i1.ts_valid = 1'b0; i1.ts_data = '0; i1.byte_ready = 1'b0;
        i4.ts_valid = 1'b0; i4.ts_data = '0; i4.byte_ready = 1'b0;
        tick();
        tick();
        chk("rst_tsrdy", 64'(i1.ts_ready), 64'd0);
        chk("rst_valid", 64'(i1.byte_valid), 64'd0);
        chk("rst_data", 64'(i1.byte_data), 64'd0);
        chk("rst_busy", 64'(i1.busy), 64'd0);
        rst = 1'b0;
        i1.byte_ready = 1'b1;
        tick();
        chk("idle_tsrdy", 64'(i1.ts_ready), 64'd1);
        // T1: plain frame at full rate
        accept(64'h0123_4567_89AB_CDEF, 1'b0);
        frame("t1", exp1, -1);
        // T2: consumer stalls on the third byte
        accept(64'h0123_4567_89AB_CDEF, 1'b0);
        frame("t2", exp1, 2);
        // T3: next word held valid throughout the frame
        accept(64'h0123_4567_89AB_CDEF, 1'b1);
        i1.ts_data = 64'hFFFF_FFFF_FFFF_FFFF;
        frame("t3a", exp1, -1);
        tick();
        i1.ts_valid = 1'b0;
        frame("t3b", exp3, -1);
        // T5: reset during the sixth digit aborts the frame
        accept(64'h0123_4567_89AB_CDEF, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk("t5_pre_data", 64'(i1.byte_data), 64'h35);
        rst = 1'b1;
        tick();
        chk("t5_rst_valid", 64'(i1.byte_valid), 64'd0);
        chk("t5_rst_busy", 64'(i1.busy), 64'd0);
        chk("t5_rst_tsrdy", 64'(i1.ts_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("t5_post_tsrdy", 64'(i1.ts_ready), 64'd1);
        tick();
        chk("t5_no_trail", 64'(i1.byte_valid), 64'd0);
        accept(64'h0123_4567_89AB_CDEF, 1'b0);
        frame("t5", exp1, -1);
        // T4: 16-bit lowercase, no prefix, no CR LF
        i4.byte_ready = 1'b1;
        i4.ts_data    = 16'hBEEF;
        i4.ts_valid   = 1'b1;
        tick();
        i4.ts_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_valid", 64'(i4.byte_valid), 64'd1);
            chk("t4_data", 64'(i4.byte_data), 64'(exp4[i]));
            tick();
        end
        chk("t4_end_valid", 64'(i4.byte_valid), 64'd0);
        chk("t4_end_tsrdy", 64'(i4.ts_ready), 64'd1);
        chk("t4_end_busy", 64'(i4.busy), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
